ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard on the same PS2_CLK/PS2_DAT pair that the existing keyboard receive path listens on.
- Implements the full open-drain request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, device ack.
- Reports completion or failure with one-cycle pulses.
- Asserts rx_inhibit while busy, so the receive path and the up/down/left/right decode ignore host-generated traffic.

Parameters:
- INHIBIT_CYCLES, 5000, cycles PS2 clock is held low before the request (100 us at 50 MHz).
- REQ_CYCLES, 10, cycles data and clock are both held low before clock release.
- TIMEOUT_CYCLES, 750000, maximum cycles from clock release to ack completion (15 ms).
- FILTER_CYCLES, 8, consecutive stable samples required to accept a ps2_clk_in level change.
- MAX_RETRIES, 2, extra attempts after a failure (used only with PS2_TX_RETRY_EN).

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-low reset
- tx_data  in  8  command byte to send
- tx_valid  in  1  request; accepted when tx_ready=1
- tx_ready  out  1  idle and able to accept a byte
- ps2_clk_in  in  1  raw PS2_CLK pad level (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pad level (asynchronous)
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (pad tri-state at top level)
- ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release
- rx_inhibit  out  1  high from acceptance until done/error
- tx_done  out  1  one-cycle pulse on successful ack
- tx_error  out  1  one-cycle pulse on NACK or timeout
- err_nack  out  1  qualifies tx_error: 1 = NACK, 0 = timeout; holds until the next acceptance

Behaviour:
- Reset: all outputs are registered.
  - tx_ready=1; ps2_clk_oe=0, ps2_dat_oe=0, rx_inhibit=0, tx_done=0, tx_error=0, err_nack=0.
  - State is IDLE and all counters are 0.
  - A reset mid-frame releases both lines on the cycle after reset is sampled low.
- Input conditioning: ps2_clk_in and ps2_dat_in pass through 2-FF synchronizers. The filtered clock produces a one-cycle fall pulse on each high-to-low transition.
- Parity: par = ~^tx_data (odd parity), latched together with the byte at acceptance.
- IDLE: tx_ready=1. On tx_valid=1:
  - latch the byte, clear err_nack;
  - next cycle: tx_ready=0, rx_inhibit=1, ps2_clk_oe=1, go to INHIBIT.
- tx_valid while tx_ready=0 is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES, then REQ.
- REQ: ps2_clk_oe=1 and ps2_dat_oe=1 (start bit 0) for REQ_CYCLES. Then ps2_clk_oe=0 and go to SHIFT with edge_cnt=0; the timeout counter starts.
- SHIFT: on each fall pulse, edge_cnt increments and the line is updated as follows:
  - edges 1..8: drive data bit edge_cnt-1 (ps2_dat_oe = ~bit);
  - edge 9: drive par;
  - edge 10: ps2_dat_oe=0 (stop bit 1);
  - edge 11: sample synced data; 0 goes to ACK_WAIT, 1 is a NACK failure.
- ACK_WAIT: wait for synced clock=1 and data=1, then pulse tx_done and return to IDLE with rx_inhibit=0.
- Timeout: the counter reaches TIMEOUT_CYCLES in SHIFT or ACK_WAIT. This is a timeout failure.
- Failure: release both lines, pulse tx_error, set err_nack, go to IDLE.
- Simultaneous events: if timeout and edge 11 occur in the same cycle, timeout wins.
- Latency: acceptance to first fall-edge wait = 1 + INHIBIT_CYCLES + REQ_CYCLES cycles.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on a failure, if retry_cnt < MAX_RETRIES:
  - release both lines for 1 cycle;
  - increment retry_cnt;
  - restart at INHIBIT with the same byte and parity;
  - no tx_error pulse for that attempt.
  - tx_error fires only after MAX_RETRIES+1 failed attempts. retry_cnt clears on acceptance.
- Not defined: the first failure pulses tx_error immediately; no retry_cnt register exists.

Decomposition:
- ps2_pkg: state enum (IDLE, INHIBIT, REQ, SHIFT, ACK_WAIT); command constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_ACK=8'hFA.
- Sub-module ps2_edge_detect: synchronizer, FILTER_CYCLES glitch filter, fall pulse. It is instantiated once for the clock; data uses a plain synchronizer.

Test Plan:
- Bench settings: INHIBIT_CYCLES=50, REQ_CYCLES=10, TIMEOUT_CYCLES=2000.
- tx_data=8'hED with a BFM device clocking 11 edges and acking low -> data seen LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; clk_oe held low exactly 60 cycles.
- tx_data=8'hF4 -> parity 0; tx_data=8'hFF -> parity 1; tx_done each time; tx_error never asserts.
- BFM leaves data high at edge 11 -> tx_error=1 for 1 cycle, err_nack=1, both oe=0, tx_ready=1 next cycle.
- BFM never clocks -> tx_error at clock-release+2000 cycles, err_nack=0.
- Second tx_valid pulse at edge 4 -> ignored, single frame only.
- Reset low at edge 5 -> oe=0 next cycle, tx_ready=1.
- With PS2_TX_RETRY_EN, NACK twice then ack -> three inhibit sequences, tx_done once, no tx_error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and command codes for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INHIBIT  = 3'd1,
        REQ      = 3'd2,
        SHIFT    = 3'd3,
        ACK_WAIT = 3'd4
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_ACK      = 8'hFA;

endpackage

// File: rtl/ps2_edge_detect.sv
// Pad synchronizer plus glitch filter for PS2_CLK; emits a one-cycle pulse
// on each accepted high-to-low transition of the filtered level.
module ps2_edge_detect
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // The bus idles high, so the filtered level starts high out of reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            level      <= 1'b1;
            fall       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            fall   <= 1'b0;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_CYCLES - 1)) begin
                level      <= sync_2;
                fall       <= ~sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, 11-edge shift, ack).
// Optional PS2_TX_RETRY_EN: retries a failed frame up to MAX_RETRIES times.
//
// state    | meaning
// IDLE     | lines released, waiting for tx_valid
// INHIBIT  | clock held low before request-to-send
// REQ      | clock and data low (start bit) before clock release
// SHIFT    | device clocks out data, parity, stop; ack sampled on edge 11
// ACK_WAIT | waiting for device to release clock and data
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRIES    = 2
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic       err_nack
);

    localparam int WW = $clog2((INHIBIT_CYCLES > REQ_CYCLES ? INHIBIT_CYCLES : REQ_CYCLES) + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state;
    logic [7:0]    tx_byte;
    logic          par;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    edge_cnt;
    logic          clk_level;
    logic          clk_fall;
    logic          dat_s1;
    logic          dat_s2;
    logic          timeout_now;
    logic          nack_now;
`ifdef PS2_TX_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_cnt;
`endif

    ps2_edge_detect #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_edge (
        .clock (clock),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    // Timeout outranks a NACK sampled on the same cycle.
    always_comb begin
        timeout_now = 1'b0;
        nack_now    = 1'b0;
        if ((state == SHIFT || state == ACK_WAIT) && tmo_cnt == '0)
            timeout_now = 1'b1;
        else if (state == SHIFT && clk_fall && edge_cnt == 4'd10 && dat_s2)
            nack_now = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            tx_byte    <= '0;
            par        <= 1'b0;
            wait_cnt   <= '0;
            tmo_cnt    <= '0;
            edge_cnt   <= '0;
            tx_ready   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            rx_inhibit <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            err_nack   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (timeout_now || nack_now) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                err_nack   <= nack_now;
`ifdef PS2_TX_RETRY_EN
                // One released cycle, then a full inhibit period on re-entry.
                if (retry_cnt < RW'(MAX_RETRIES)) begin
                    retry_cnt <= retry_cnt + RW'(1);
                    wait_cnt  <= WW'(INHIBIT_CYCLES);
                    state     <= INHIBIT;
                end else
`endif
                begin
                    tx_error   <= 1'b1;
                    tx_ready   <= 1'b1;
                    rx_inhibit <= 1'b0;
                    state      <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            tx_byte    <= tx_data;
                            par        <= ~^tx_data;
                            err_nack   <= 1'b0;
                            tx_ready   <= 1'b0;
                            rx_inhibit <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            wait_cnt   <= WW'(INHIBIT_CYCLES - 1);
                            state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retry_cnt  <= '0;
`endif
                        end
                    end
                    INHIBIT: begin
                        ps2_clk_oe <= 1'b1;
                        if (wait_cnt == '0) begin
                            ps2_dat_oe <= 1'b1;
                            wait_cnt   <= WW'(REQ_CYCLES - 1);
                            state      <= REQ;
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end
                    REQ: begin
                        if (wait_cnt == '0) begin
                            ps2_clk_oe <= 1'b0;
                            tmo_cnt    <= TW'(TIMEOUT_CYCLES - 1);
                            edge_cnt   <= '0;
                            state      <= SHIFT;
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end
                    SHIFT: begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (clk_fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (edge_cnt < 4'd8)
                                ps2_dat_oe <= ~tx_byte[edge_cnt[2:0]];
                            else if (edge_cnt == 4'd8)
                                ps2_dat_oe <= ~par;
                            else if (edge_cnt == 4'd9)
                                ps2_dat_oe <= 1'b0;
                            else
                                state <= ACK_WAIT;
                        end
                    end
                    ACK_WAIT: begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (clk_level && dat_s2) begin
                            tx_done    <= 1'b1;
                            tx_ready   <= 1'b1;
                            rx_inhibit <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
